tea_req_scheduler: RTL and testbench

- Shares one iterative TEA round engine between NUM_REQ requesters.
- Round-robin arbitration picks one request. The block latches the 64-bit block and 128-bit key, runs 32 rounds at one round per cycle, then returns the result with the requester ID.
- Sits between block producers (test harness, UART loader) and result consumers. It replaces the free-running single-vector encryptor.

---
 rtl/tea_pkg.sv | 38 +++
 rtl/tea_round.sv | 35 +++
 rtl/tea_req_scheduler.sv | 167 ++++++++++++++++
 tb/tb_tea_req_scheduler.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tea_pkg.sv
// Shared constants and types for the TEA request scheduler and its round datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tea_pkg;

    localparam logic [31:0] DELTA        = 32'h9E3779B9;
    localparam int          NUM_ROUNDS   = 32;
    localparam logic [31:0] SUM_INIT_DEC = 32'hC6EF3720;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // {v0, v1}: v0 occupies the upper word
    typedef struct packed {
        logic [31:0] v0;
        logic [31:0] v1;
    } block_t;

    // {k0, k1, k2, k3}: k0 occupies the upper word
    typedef struct packed {
        logic [31:0] k0;
        logic [31:0] k1;
        logic [31:0] k2;
        logic [31:0] k3;
    } key_t;

    // TEA mixing term for one half-round
    function automatic logic [31:0] tea_mix(input logic [31:0] x,
                                            input logic [31:0] ka,
                                            input logic [31:0] kb,
                                            input logic [31:0] s);
        return ((x << 4) + ka) ^ (x + s) ^ ((x >> 5) + kb);
    endfunction

endpackage

// File: rtl/tea_round.sv
// One TEA round (encrypt, or decrypt when dec_i=1), purely combinational.
// Latency: 0 cycles.
// Backpressure: none; the caller decides when to register the outputs.
module tea_round
    import tea_pkg::*;
(
    input  logic [31:0] v0_i,
    input  logic [31:0] v1_i,
    input  key_t        key_i,
    input  logic [31:0] sum_i,
    input  logic        dec_i,
    output logic [31:0] v0_o,
    output logic [31:0] v1_o,
    output logic [31:0] sum_o
);

    logic [31:0] enc_sum;
    logic [31:0] enc_v0;
    logic [31:0] enc_v1;
    logic [31:0] dec_v0;
    logic [31:0] dec_v1;

    // Encrypt advances sum first and uses it; decrypt uses sum then retreats it.
    always_comb begin
        enc_sum = sum_i + DELTA;
        enc_v0  = v0_i + tea_mix(v1_i, key_i.k0, key_i.k1, enc_sum);
        enc_v1  = v1_i + tea_mix(enc_v0, key_i.k2, key_i.k3, enc_sum);
        dec_v1  = v1_i - tea_mix(v0_i, key_i.k2, key_i.k3, sum_i);
        dec_v0  = v0_i - tea_mix(dec_v1, key_i.k0, key_i.k1, sum_i);
        v0_o    = dec_i ? dec_v0 : enc_v0;
        v1_o    = dec_i ? dec_v1 : enc_v1;
        sum_o   = dec_i ? (sum_i - DELTA) : enc_sum;
    end

endmodule

// File: rtl/tea_req_scheduler.sv
// Round-robin shares one iterative TEA engine among NUM_REQ requesters (TEA_DECRYPT_EN adds decrypt mode).
// Latency: resp_valid_o rises 32 cycles after the accept edge; one round per cycle.
// Backpressure: req_ready_o only in IDLE; result holds in DONE until resp_ready_i; next accept one cycle after.
module tea_req_scheduler
    import tea_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    input  logic [64*NUM_REQ-1:0]  req_data_i,
    input  logic [127:0]           key_i,
    output logic                   resp_valid_o,
    input  logic                   resp_ready_i,
    output logic [63:0]            resp_data_o,
    output logic [ID_W-1:0]        resp_id_o,
    output logic                   busy_o,
    output logic [5:0]             round_cnt_o
`ifdef TEA_DECRYPT_EN
    ,
    input  logic [NUM_REQ-1:0]     req_dec_i,
    output logic                   resp_dec_o
`endif
);

    state_t          state_q, state_d;
    logic [ID_W-1:0] rr_q, rr_d;
    block_t          blk_q, blk_d;
    key_t            key_q, key_d;
    logic [31:0]     sum_q, sum_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [ID_W-1:0] id_q, id_d;
    logic            run_dec;

    logic            gnt_vld;
    logic [ID_W-1:0] gnt_idx;
    logic [ID_W:0]   cand;
    logic            gnt_dec;
    block_t          req_blk [NUM_REQ];
    logic [31:0]     rnd_v0, rnd_v1, rnd_sum;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign req_blk[g] = req_data_i[64*g +: 64];
    end

`ifdef TEA_DECRYPT_EN
    logic dec_q, dec_d;
    assign run_dec    = dec_q;
    assign gnt_dec    = req_dec_i[gnt_idx];
    assign resp_dec_o = dec_q;
`else
    assign run_dec = 1'b0;
    assign gnt_dec = 1'b0;
`endif

    // Round-robin search from rr_q upward; the wrap is at NUM_REQ, not 2**ID_W.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (req_valid_i[cand[ID_W-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand[ID_W-1:0];
            end
        end
    end

    tea_round u_round (
        .v0_i  (blk_q.v0),
        .v1_i  (blk_q.v1),
        .key_i (key_q),
        .sum_i (sum_q),
        .dec_i (run_dec),
        .v0_o  (rnd_v0),
        .v1_o  (rnd_v1),
        .sum_o (rnd_sum)
    );

    // FSM next state, datapath next values and the combinational accept strobe.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        blk_d       = blk_q;
        key_d       = key_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        id_d        = id_q;
        req_ready_o = '0;
`ifdef TEA_DECRYPT_EN
        dec_d       = dec_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    req_ready_o[gnt_idx] = 1'b1;
                    blk_d   = req_blk[gnt_idx];
                    key_d   = key_t'(key_i);
                    sum_d   = gnt_dec ? SUM_INIT_DEC : 32'h0;
                    cnt_d   = '0;
                    id_d    = gnt_idx;
                    rr_d    = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    state_d = ST_RUN;
`ifdef TEA_DECRYPT_EN
                    dec_d   = gnt_dec;
`endif
                end
            end
            ST_RUN: begin
                blk_d = {rnd_v0, rnd_v1};
                sum_d = rnd_sum;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'(NUM_ROUNDS - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Returning to IDLE first keeps a new grant out of the handshake cycle.
                if (resp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any block in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            rr_q    <= '0;
            blk_q   <= '0;
            key_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            id_q    <= '0;
`ifdef TEA_DECRYPT_EN
            dec_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            blk_q   <= blk_d;
            key_q   <= key_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
`ifdef TEA_DECRYPT_EN
            dec_q   <= dec_d;
`endif
        end
    end

    assign resp_valid_o = (state_q == ST_DONE);
    assign busy_o       = (state_q != ST_IDLE);
    assign resp_data_o  = blk_q;
    assign resp_id_o    = id_q;
    assign round_cnt_o  = cnt_q;

endmodule

// File: tb/tb_tea_req_scheduler.sv
// Bench for tea_req_scheduler: randomized requests against a loop-level TEA and round-robin model.
// Latency: checks the 32-cycle accept-to-result latency on every transaction.
// Backpressure: exercises a held-off consumer and the idle cycle after each result handshake.
module tb_tea_req_scheduler;

    localparam int          NR      = 4;
    localparam int          IW      = 2;
    localparam logic [31:0] M_DELTA = 32'h9E3779B9;
    localparam logic [31:0] M_DSUM  = 32'hC6EF3720;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NR-1:0]       req_valid;
    logic [NR-1:0]       req_ready;
    logic [64*NR-1:0]    req_data;
    logic [127:0]        key;
    logic                resp_valid;
    logic                resp_ready;
    logic [63:0]         resp_data;
    logic [IW-1:0]       resp_id;
    logic                busy;
    logic [5:0]          round_cnt;
`ifdef TEA_DECRYPT_EN
    logic [NR-1:0]       req_dec;
    logic                resp_dec;
`endif

    int checks = 0;
    int errors = 0;
    int m_rr   = 0;

    logic [63:0]  vec_pt;
    logic [127:0] vec_key;

    always #5 clk = ~clk;

    tea_req_scheduler #(.NUM_REQ(NR), .ID_W(IW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_data_i   (req_data),
        .key_i        (key),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_data_o  (resp_data),
        .resp_id_o    (resp_id),
        .busy_o       (busy),
        .round_cnt_o  (round_cnt)
`ifdef TEA_DECRYPT_EN
        ,
        .req_dec_i    (req_dec),
        .resp_dec_o   (resp_dec)
`endif
    );

    // Reference TEA encryption: 32 iterations of the textbook algorithm.
    function automatic logic [63:0] ref_enc(input logic [63:0] b, input logic [127:0] k);
        logic [31:0] y, z, s;
        y = b[63:32]; z = b[31:0]; s = 32'h0;
        for (int r = 0; r < 32; r++) begin
            s = s + M_DELTA;
            y = y + (((z << 4) + k[127:96]) ^ (z + s) ^ ((z >> 5) + k[95:64]));
            z = z + (((y << 4) + k[63:32]) ^ (y + s) ^ ((y >> 5) + k[31:0]));
        end
        return {y, z};
    endfunction

    // Reference TEA decryption.
    function automatic logic [63:0] ref_dec(input logic [63:0] b, input logic [127:0] k);
        logic [31:0] y, z, s;
        y = b[63:32]; z = b[31:0]; s = M_DSUM;
        for (int r = 0; r < 32; r++) begin
            z = z - (((y << 4) + k[63:32]) ^ (y + s) ^ ((y >> 5) + k[31:0]));
            y = y - (((z << 4) + k[127:96]) ^ (z + s) ^ ((z >> 5) + k[95:64]));
            s = s - M_DELTA;
        end
        return {y, z};
    endfunction

    // Round-robin reference: first set bit at or after ptr, wrapping at NR.
    function automatic int rr_pick(input logic [NR-1:0] mask, input int ptr);
        for (int k = 0; k < NR; k++) begin
            if (mask[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return -1;
    endfunction

    function automatic logic [63:0] slice(input int i);
        return req_data[64*i +: 64];
    endfunction

    // Drive one request set, accept, and collect the result (entered and left at posedge+1).
    task automatic run_txn(input logic [NR-1:0] mask, input bit key_chg,
                           output int gnt, output logic [NR-1:0] rdy, output int lat,
                           output logic [63:0] rdata, output int rid, output logic rdec);
        int c;
        gnt = -1; rdy = '0; lat = -1; rdata = '0; rid = -1; rdec = 1'b0;
        req_valid = mask;
        #1;
        c = 0;
        while (req_ready == '0 && c < 100) begin
            @(posedge clk); #2; c++;
        end
        rdy = req_ready;
        if (req_ready == '0) begin
            req_valid = '0;
            return;
        end
        for (int i = 0; i < NR; i++) if (req_ready[i]) gnt = i;
        @(posedge clk); #1;
        req_valid = '0;
        if (key_chg) key = '0;
        c = 0;
        while (!resp_valid && c < 100) begin
            @(posedge clk); #1; c++;
        end
        if (resp_valid) lat = c;
        rdata = resp_data;
        rid   = int'(resp_id);
`ifdef TEA_DECRYPT_EN
        rdec  = resp_dec;
`endif
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '0; resp_ready = 1'b0; req_data = '0; key = '0;
`ifdef TEA_DECRYPT_EN
        req_dec = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
        checks++; if (resp_data !== 64'h0) begin errors++; $display("FAIL reset_resp_data got %h want 0", resp_data); end
        checks++; if (resp_id !== 2'd0) begin errors++; $display("FAIL reset_resp_id got %0d want 0", resp_id); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (round_cnt !== 6'd0) begin errors++; $display("FAIL reset_round_cnt got %0d want 0", round_cnt); end
        rst_n = 1'b1;
        m_rr = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_round_robin();
        int gnt, lat, rid, eg; logic [NR-1:0] rdy, erdy; logic [63:0] rd; logic rdec;
        for (int i = 0; i < NR; i++) req_data[64*i +: 64] = {$urandom, $urandom};
        key = {$urandom, $urandom, $urandom, $urandom};
        for (int t = 0; t < 5; t++) begin
            logic [NR-1:0] mask;
            mask = (t < 4) ? 4'b1111 : 4'b1000;
            if (t == 4) repeat (2) @(posedge clk);
            #0;
            eg = rr_pick(mask, m_rr);
            erdy = '0; erdy[eg] = 1'b1;
            run_txn(mask, 1'b0, gnt, rdy, lat, rd, rid, rdec);
            checks++; if (gnt != eg) begin errors++; $display("FAIL rr_grant t=%0d got %0d want %0d", t, gnt, eg); end
            checks++; if (rdy !== erdy) begin errors++; $display("FAIL rr_ready t=%0d got %b want %b", t, rdy, erdy); end
            checks++; if (rid != eg) begin errors++; $display("FAIL rr_id t=%0d got %0d want %0d", t, rid, eg); end
            checks++; if (rd !== ref_enc(slice(eg), key)) begin errors++; $display("FAIL rr_data t=%0d got %h want %h", t, rd, ref_enc(slice(eg), key)); end
            checks++; if (lat != 32) begin errors++; $display("FAIL rr_latency t=%0d got %0d want 32", t, lat); end
            m_rr = (eg + 1) % NR;
        end
    endtask

    task automatic test_single();
        int gnt, lat, rid; logic [NR-1:0] rdy; logic [63:0] rd; logic rdec;
        req_data[63:0] = vec_pt;
        key = vec_key;
        run_txn(4'b0001, 1'b0, gnt, rdy, lat, rd, rid, rdec);
        checks++; if (gnt != 0) begin errors++; $display("FAIL single_grant got %0d want 0", gnt); end
        checks++; if (lat != 32) begin errors++; $display("FAIL single_latency got %0d want 32", lat); end
        checks++; if (rd !== ref_enc(vec_pt, vec_key)) begin errors++; $display("FAIL single_data got %h want %h", rd, ref_enc(vec_pt, vec_key)); end
        checks++; if (rid != 0) begin errors++; $display("FAIL single_id got %0d want 0", rid); end
        m_rr = 1;
    endtask

    task automatic test_backpressure();
        int eg, eg2, c; logic [63:0] exp; logic [NR-1:0] erdy;
        req_data[127:64] = {$urandom, $urandom};
        key = {$urandom, $urandom, $urandom, $urandom};
        req_valid = 4'b0010;
        eg = rr_pick(4'b0010, m_rr);
        exp = ref_enc(slice(eg), key);
        @(posedge clk); #1;
        m_rr = (eg + 1) % NR;
        req_valid = 4'b1111;
        c = 0;
        while (!resp_valid && c < 100) begin @(posedge clk); #1; c++; end
        checks++; if (c != 32) begin errors++; $display("FAIL bp_latency got %0d want 32", c); end
        for (int i = 0; i < 10; i++) begin
            checks++; if (resp_data !== exp || resp_id != eg[IW-1:0]) begin errors++; $display("FAIL bp_hold i=%0d got %h/%0d want %h/%0d", i, resp_data, resp_id, exp, eg); end
            checks++; if (req_ready !== 4'b0000 || busy !== 1'b1 || resp_valid !== 1'b1) begin errors++; $display("FAIL bp_ctrl i=%0d rdy=%b busy=%b vld=%b want 0000/1/1", i, req_ready, busy, resp_valid); end
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_no_same_cycle_grant got %b want 0000", req_ready); end
        @(posedge clk); #1;
        resp_ready = 1'b0;
        eg2 = rr_pick(4'b1111, m_rr);
        erdy = '0; erdy[eg2] = 1'b1;
        checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_release vld=%b busy=%b want 0/0", resp_valid, busy); end
        checks++; if (req_ready !== erdy) begin errors++; $display("FAIL bp_next_grant got %b want %b", req_ready, erdy); end
        @(posedge clk); #1;
        req_valid = '0;
        m_rr = (eg2 + 1) % NR;
        checks++; if (busy !== 1'b1 || round_cnt !== 6'd0) begin errors++; $display("FAIL bp_next_accept busy=%b cnt=%0d want 1/0", busy, round_cnt); end
        exp = ref_enc(slice(eg2), key);
        c = 0;
        while (!resp_valid && c < 100) begin @(posedge clk); #1; c++; end
        checks++; if (resp_data !== exp || resp_id != eg2[IW-1:0]) begin errors++; $display("FAIL bp_next_result got %h/%0d want %h/%0d", resp_data, resp_id, exp, eg2); end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int c, gnt, lat, rid; logic [NR-1:0] rdy; logic [63:0] rd; logic rdec; bit seen;
        req_data[63:0] = vec_pt;
        key = vec_key;
        req_valid = 4'b0001;
        #1;
        @(posedge clk); #1;
        req_valid = '0;
        c = 0;
        while (round_cnt != 6'd15 && c < 100) begin @(posedge clk); #1; c++; end
        checks++; if (round_cnt !== 6'd15) begin errors++; $display("FAIL mid_reach_15 got %0d want 15", round_cnt); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 4'b0000) begin errors++; $display("FAIL mid_reset_ctrl busy=%b vld=%b rdy=%b want 0/0/0000", busy, resp_valid, req_ready); end
        checks++; if (resp_data !== 64'h0 || resp_id !== 2'd0 || round_cnt !== 6'd0) begin errors++; $display("FAIL mid_reset_data got %h/%0d/%0d want 0/0/0", resp_data, resp_id, round_cnt); end
        seen = 1'b0;
        repeat (3) begin @(posedge clk); #1; if (resp_valid) seen = 1'b1; end
        rst_n = 1'b1;
        repeat (40) begin @(posedge clk); #1; if (resp_valid) seen = 1'b1; end
        checks++; if (seen) begin errors++; $display("FAIL mid_reset_no_resp got 1 want 0"); end
        m_rr = 0;
        run_txn(4'b0011, 1'b0, gnt, rdy, lat, rd, rid, rdec);
        checks++; if (gnt != rr_pick(4'b0011, 0)) begin errors++; $display("FAIL mid_rr_ptr_cleared got %0d want %0d", gnt, rr_pick(4'b0011, 0)); end
        checks++; if (rd !== ref_enc(vec_pt, vec_key) || lat != 32) begin errors++; $display("FAIL mid_after_data got %h lat %0d want %h lat 32", rd, lat, ref_enc(vec_pt, vec_key)); end
        m_rr = 1;
    endtask

    task automatic test_key_change();
        int gnt, lat, rid; logic [NR-1:0] rdy; logic [63:0] rd; logic rdec;
        req_data[63:0] = vec_pt;
        key = vec_key;
        run_txn(4'b0001, 1'b1, gnt, rdy, lat, rd, rid, rdec);
        checks++; if (rd !== ref_enc(vec_pt, vec_key)) begin errors++; $display("FAIL key_change_data got %h want %h", rd, ref_enc(vec_pt, vec_key)); end
        m_rr = 1;
    endtask

`ifdef TEA_DECRYPT_EN
    task automatic test_decrypt();
        int gnt, lat, rid; logic [NR-1:0] rdy; logic [63:0] rd, ct; logic rdec;
        ct = 64'h5CF85E83_E967E1FD;
        req_data[63:0] = ct;
        key = vec_key;
        req_dec = 4'b0001;
        run_txn(4'b0001, 1'b0, gnt, rdy, lat, rd, rid, rdec);
        req_dec = '0;
        checks++; if (rd !== ref_dec(ct, vec_key)) begin errors++; $display("FAIL decrypt_data got %h want %h", rd, ref_dec(ct, vec_key)); end
        checks++; if (rdec !== 1'b1 || lat != 32) begin errors++; $display("FAIL decrypt_mode dec=%b lat=%0d want 1/32", rdec, lat); end
        m_rr = 1;
    endtask
`endif

    task automatic test_random();
        int gnt, lat, rid, eg; logic [NR-1:0] rdy, erdy, mask, dmask; logic [63:0] rd, exp; logic rdec;
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < NR; i++) req_data[64*i +: 64] = {$urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
            mask = NR'($urandom_range(1, 15));
            dmask = '0;
`ifdef TEA_DECRYPT_EN
            dmask = NR'($urandom);
            req_dec = dmask;
`endif
            eg = rr_pick(mask, m_rr);
            erdy = '0; erdy[eg] = 1'b1;
            exp = dmask[eg] ? ref_dec(slice(eg), key) : ref_enc(slice(eg), key);
            run_txn(mask, 1'b0, gnt, rdy, lat, rd, rid, rdec);
            checks++; if (rdy !== erdy || rid != eg) begin errors++; $display("FAIL rand_grant t=%0d rdy=%b id=%0d want %b/%0d", t, rdy, rid, erdy, eg); end
            checks++; if (rd !== exp || lat != 32) begin errors++; $display("FAIL rand_data t=%0d got %h lat %0d want %h lat 32", t, rd, lat, exp); end
            checks++; if (rdec !== dmask[eg]) begin errors++; $display("FAIL rand_dec t=%0d got %b want %b", t, rdec, dmask[eg]); end
            m_rr = (eg + 1) % NR;
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_pt  = 64'h12345678_9ABCDEF0;
        vec_key = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        test_reset();
        test_round_robin();
        test_single();
        test_backpressure();
        test_reset_mid_run();
        test_key_change();
`ifdef TEA_DECRYPT_EN
        test_decrypt();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
